// File: rtl/instr_decode_ctrl_if.sv
// Instruction handshake between the fetch side (master) and instr_decode_ctrl (slave).
interface instr_decode_ctrl_if;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr_in, output instr_valid, input instr_ready);
  modport slave  (input instr_in, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle RV32I control unit (OP, OP-IMM, LUI) sequencing DECODE/EXEC/WB for the datapath.
// Optional statistics counters are enabled with `define DECODE_STATS_EN.
module instr_decode_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  instr_decode_ctrl_if.slave bus,
  output logic [6:0]         op,
  output logic [4:0]         addr_a,
  output logic [4:0]         addr_b,
  output logic [4:0]         addr_d,
  output logic [31:0]        immed,
  output logic               y_sel,
  output logic               write,
  output logic               busy,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired_count,
  output logic [CNT_W-1:0]   illegal_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr;
  logic        w_hs;
  logic        w_legal;
  logic [6:0]  w_op;
  logic [4:0]  w_addr_a;
  logic [4:0]  w_addr_b;
  logic [31:0] w_immed;
  logic        w_y_sel;

  wire [6:0] w_opcode = r_instr[6:0];
  wire [4:0] w_rd     = r_instr[11:7];
  wire [2:0] w_funct3 = r_instr[14:12];
  wire [4:0] w_rs1    = r_instr[19:15];
  wire [4:0] w_rs2    = r_instr[24:20];
  wire       w_alt    = r_instr[30];

  assign bus.instr_ready = (r_state == S_IDLE) && !rst;
  assign busy            = (r_state != S_IDLE);
  assign w_hs            = bus.instr_valid && bus.instr_ready;

  // Field decode of the latched instruction; illegal opcodes still expose the raw register fields.
  always_comb begin
    w_legal  = 1'b0;
    w_op     = 7'd0;
    w_addr_a = 5'd0;
    w_addr_b = 5'd0;
    w_immed  = 32'd0;
    w_y_sel  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_legal  = 1'b1;
        w_op     = {3'b000, w_alt, w_funct3};
        w_addr_a = w_rs1;
        w_addr_b = w_rs2;
        w_y_sel  = 1'b1;
      end
      OPC_OP_IMM: begin
        w_legal  = 1'b1;
        w_addr_a = w_rs1;
        if (w_funct3 == 3'b101) begin
          w_op = {3'b000, w_alt, w_funct3};
        end else begin
          w_op = {3'b000, 1'b0, w_funct3};
        end
        if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
          w_immed = {27'd0, r_instr[24:20]};
        end else begin
          w_immed = {{20{r_instr[31]}}, r_instr[31:20]};
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_immed = {r_instr[31:12], 12'd0};
      end
      default: begin
        w_legal  = 1'b0;
        w_addr_a = w_rs1;
        w_addr_b = w_rs2;
      end
    endcase
  end

  // Next-state logic for the IDLE -> DECODE -> EXEC -> WB sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next_state = S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, instruction latch and registered datapath controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= 32'd0;
      op      <= 7'd0;
      addr_a  <= 5'd0;
      addr_b  <= 5'd0;
      addr_d  <= 5'd0;
      immed   <= 32'd0;
      y_sel   <= 1'b0;
      write   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_hs) begin
        r_instr <= bus.instr_in;
      end
      if (r_state == S_DECODE) begin
        op      <= w_op;
        addr_a  <= w_addr_a;
        addr_b  <= w_addr_b;
        addr_d  <= w_rd;
        immed   <= w_immed;
        y_sel   <= w_y_sel;
        illegal <= !w_legal;
      end else begin
        illegal <= 1'b0;
      end
      // addr_d was captured at the end of DECODE, so it is valid while in EXEC.
      write <= (r_state == S_EXEC) && (addr_d != 5'd0);
    end
  end

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_illegal_cnt;

  // Retired and illegal statistics, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired     <= {CNT_W{1'b0}};
      r_illegal_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_state == S_WB) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if ((r_state == S_DECODE) && !w_legal) begin
        r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
    end
  end

  assign retired_count = r_retired;
  assign illegal_count = r_illegal_cnt;
`else
  assign retired_count = {CNT_W{1'b0}};
  assign illegal_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl: per-cycle behavioural model plus literal spot checks.
module tb_instr_decode_ctrl;
  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [4:0]  addr_a, addr_b, addr_d;
  logic [31:0] immed;
  logic        y_sel, write, busy, illegal;
  logic [15:0] retired_count, illegal_count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_decode_ctrl_if bus ();

  instr_decode_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .immed(immed), .y_sel(y_sel), .write(write), .busy(busy), .illegal(illegal),
    .retired_count(retired_count), .illegal_count(illegal_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          legal;
    logic [6:0]  op;
    logic [4:0]  a, b, d;
    logic [31:0] imm;
    logic        ysel;
  } dec_t;

  function automatic dec_t model_decode(input logic [31:0] w);
    dec_t r;
    logic [2:0] f3;
    f3 = w[14:12];
    r = '{legal: 1'b0, op: 7'd0, a: 5'd0, b: 5'd0, d: w[11:7], imm: 32'd0, ysel: 1'b0};
    case (w[6:0])
      7'b0110011: begin
        r.legal = 1'b1; r.op = {3'b000, w[30], f3};
        r.a = w[19:15]; r.b = w[24:20]; r.ysel = 1'b1;
      end
      7'b0010011: begin
        r.legal = 1'b1; r.a = w[19:15];
        r.op = {3'b000, (f3 == 3'd5) ? w[30] : 1'b0, f3};
        r.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      end
      7'b0110111: begin
        r.legal = 1'b1; r.imm = {w[31:12], 12'd0};
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // Model: tracks edges elapsed since the accepting edge of the current instruction.
  initial begin
    bit          inflight, pend_hs, pend_rst, f_known;
    int          d;
    logic [31:0] cur, pend_instr;
    dec_t        cd;
    logic [6:0]  e_op;
    logic [4:0]  e_a, e_b, e_d;
    logic [31:0] e_imm;
    logic        e_ysel, e_busy, e_ready, e_write, e_illegal;
    logic [15:0] e_ret, e_ill;
    inflight = 0; pend_hs = 0; pend_rst = 0; f_known = 1; d = 0;
    cur = 32'd0; pend_instr = 32'd0; cd = model_decode(32'd0);
    e_op = 7'd0; e_a = 5'd0; e_b = 5'd0; e_d = 5'd0; e_imm = 32'd0; e_ysel = 1'b0;
    e_ret = 16'd0; e_ill = 16'd0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (pend_rst) begin
        inflight = 0; pend_hs = 0; pend_rst = 0; f_known = 1;
        e_op = 7'd0; e_a = 5'd0; e_b = 5'd0; e_d = 5'd0; e_imm = 32'd0; e_ysel = 1'b0;
        e_ret = 16'd0; e_ill = 16'd0;
      end else begin
        if (inflight) begin
          d++;
          if (d == 1) begin
            e_op = cd.op; e_a = cd.a; e_b = cd.b; e_d = cd.d; e_imm = cd.imm; e_ysel = cd.ysel;
            f_known = cd.legal;
`ifdef DECODE_STATS_EN
            if (!cd.legal) e_ill = e_ill + 16'd1;
`endif
          end
`ifdef DECODE_STATS_EN
          if (d == 3 && cd.legal) e_ret = e_ret + 16'd1;
`endif
          if ((cd.legal && d >= 3) || (!cd.legal && d >= 2)) inflight = 0;
        end
        if (pend_hs) begin
          inflight = 1; d = 0; cur = pend_instr; cd = model_decode(cur); pend_hs = 0;
        end
      end
      e_busy    = inflight && (d == 0 || (cd.legal && d <= 2));
      e_ready   = !e_busy && !rst;
      e_write   = inflight && cd.legal && d == 2 && cd.d != 5'd0;
      e_illegal = inflight && !cd.legal && d == 1;
      chk("m_ready", {31'd0, bus.instr_ready}, {31'd0, e_ready});
      chk("m_busy", {31'd0, busy}, {31'd0, e_busy});
      chk("m_write", {31'd0, write}, {31'd0, e_write});
      chk("m_illegal", {31'd0, illegal}, {31'd0, e_illegal});
      chk("m_retired", {16'd0, retired_count}, {16'd0, e_ret});
      chk("m_illcnt", {16'd0, illegal_count}, {16'd0, e_ill});
      if (f_known) begin
        chk("m_op", {25'd0, op}, {25'd0, e_op});
        chk("m_addr_a", {27'd0, addr_a}, {27'd0, e_a});
        chk("m_addr_b", {27'd0, addr_b}, {27'd0, e_b});
        chk("m_addr_d", {27'd0, addr_d}, {27'd0, e_d});
        chk("m_immed", immed, e_imm);
        chk("m_y_sel", {31'd0, y_sel}, {31'd0, e_ysel});
      end
      if (rst) begin
        pend_rst = 1;
      end else if (bus.instr_valid && e_ready) begin
        pend_hs = 1; pend_instr = bus.instr_in;
      end
    end
  end

  // Waits (bounded) for ready, then presents one instruction for exactly one edge.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #2; n++;
    end
    chk("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_in = w; bus.instr_valid = 1'b1;
    @(posedge clk); #2;
    bus.instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1; bus.instr_valid = 1'b0; bus.instr_in = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_op", {25'd0, op}, 32'd0);
    chk("rst_immed", immed, 32'd0);
    chk("rst_ready_in_rst", {31'd0, bus.instr_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);

    // Illegal word then ADDI x0: illegal pulse, no write, counters 1/1 with stats.
    send(32'h0000_0000);
    step();
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_ready", {31'd0, bus.instr_ready}, 32'd1);
    send(32'h0010_8013);
    repeat (3) step();
`ifdef DECODE_STATS_EN
    chk("cnt_retired", {16'd0, retired_count}, 32'd1);
    chk("cnt_illegal", {16'd0, illegal_count}, 32'd1);
`else
    chk("cnt_retired", {16'd0, retired_count}, 32'd0);
    chk("cnt_illegal", {16'd0, illegal_count}, 32'd0);
`endif

    // ADD x3,x1,x2
    send(32'h0020_81B3);
    step();
    chk("add_a", {27'd0, addr_a}, 32'd1);
    chk("add_b", {27'd0, addr_b}, 32'd2);
    chk("add_d", {27'd0, addr_d}, 32'd3);
    chk("add_ysel", {31'd0, y_sel}, 32'd1);
    chk("add_op", {25'd0, op}, 32'h00);
    chk("add_write_exec", {31'd0, write}, 32'd0);
    step();
    chk("add_write_wb", {31'd0, write}, 32'd1);
    chk("add_ready_wb", {31'd0, bus.instr_ready}, 32'd0);
    step();
    chk("add_write_after", {31'd0, write}, 32'd0);
    chk("add_ready_lat4", {31'd0, bus.instr_ready}, 32'd1);

    // ADDI x5,x0,-1
    send(32'hFFF0_0293);
    step();
    chk("addi_imm", immed, 32'hFFFF_FFFF);
    chk("addi_ysel", {31'd0, y_sel}, 32'd0);
    chk("addi_d", {27'd0, addr_d}, 32'd5);
    step();
    chk("addi_write", {31'd0, write}, 32'd1);
    step();

    // SUB with instr_valid held high while busy (must be ignored), then SRAI.
    send(32'h4020_8233);
    bus.instr_in = 32'h1234_53B7; bus.instr_valid = 1'b1;
    step();
    chk("sub_op", {25'd0, op}, 32'h08);
    step();
    bus.instr_valid = 1'b0;
    step();
    send(32'h4030_D313);
    step();
    chk("srai_op", {25'd0, op}, 32'h0D);
    chk("srai_imm", immed, 32'h0000_0003);
    repeat (2) step();

    // LUI x7,0x12345
    send(32'h1234_53B7);
    step();
    chk("lui_imm", immed, 32'h1234_5000);
    chk("lui_a", {27'd0, addr_a}, 32'd0);
    chk("lui_d", {27'd0, addr_d}, 32'd7);
    step();
    chk("lui_write", {31'd0, write}, 32'd1);
    step();

    // Reset during EXEC of ADD: no write, outputs cleared, next instruction accepted at once.
    send(32'h0020_81B3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mr_write", {31'd0, write}, 32'd0);
    chk("mr_addr_a", {27'd0, addr_a}, 32'd0);
    chk("mr_addr_d", {27'd0, addr_d}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, bus.instr_ready}, 32'd1);
    send(32'hFFF0_0293);
    step();
    chk("mr_new_d", {27'd0, addr_d}, 32'd5);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Multi-cycle control unit that drives the datapath's control inputs: ALU op, register addresses, immediate, operand select and write enable.
- Accepts one 32-bit RV32I-format instruction per transaction through a valid/ready handshake.
- Decodes the instruction and sequences read, execute and writeback for the datapath, which sits directly downstream.
- Supports R-type ALU (OP), I-type ALU (OP-IMM) and LUI. All other opcodes are flagged illegal.

Parameters:
CNT_W  16  width of the statistics counters (only used when DECODE_STATS_EN is defined)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
instr_in  input  32  instruction word; sampled on handshake
instr_valid  input  1  instr_in is valid
instr_ready  output  1  unit can accept an instruction
op  output  7  ALU operation to datapath
addr_a  output  5  source register A address
addr_b  output  5  source register B address
addr_d  output  5  destination register address
immed  output  32  immediate operand
y_sel  output  1  ALU B-operand select: 0 = immed, 1 = register B
write  output  1  register-file write enable; one-cycle pulse
busy  output  1  instruction in flight (state != IDLE)
illegal  output  1  one-cycle pulse on an undecodable instruction
retired_count  output  CNT_W  number of instructions completed via WB
illegal_count  output  CNT_W  number of illegal instructions seen

Behaviour:
- The single clock is clk. Reset rst is synchronous and active-high.
- All outputs are registered except instr_ready and busy, which are decoded from state.
- Reset values: state=IDLE; op, addr_a, addr_b, addr_d, immed and the counters are 0; y_sel, write and illegal are 0.
- instr_ready = (state==IDLE) && !rst.
- States:
  - IDLE: a handshake (instr_valid && instr_ready) latches instr_in and moves to DECODE. Otherwise stay in IDLE.
  - DECODE: drive the decoded fields onto the outputs, registered at the end of this cycle. Legal instruction -> EXEC. Illegal -> IDLE, with illegal=1 for exactly the following cycle.
  - EXEC: outputs held stable so the register-file read and the combinational ALU settle. Always -> WB.
  - WB: write=1 for this cycle only, unless addr_d==0, in which case write stays 0. Always -> IDLE.
- Latency: 4 cycles from handshake to instr_ready re-asserting (IDLE->DECODE->EXEC->WB->IDLE). Back-to-back throughput is one instruction per 4 cycles.
- Field extraction:
  - opcode = [6:0]
  - rd = [11:7]
  - funct3 = [14:12]
  - rs1 = [19:15]
  - rs2 = [24:20]
  - funct7 = [31:25]
- op encoding: op = {3'b000, alt, funct3}.
  - alt = funct7[5] for OP.
  - alt = funct7[5] for OP-IMM when funct3==101.
  - alt = 0 otherwise.
- OP (0110011): addr_a=rs1, addr_b=rs2, addr_d=rd, y_sel=1, immed=0.
- OP-IMM (0010011): addr_a=rs1, addr_b=0, addr_d=rd, y_sel=0.
  - funct3 001/101: immed = {27'b0, instr[24:20]} (shift amount).
  - Otherwise: immed = sign-extended instr[31:20].
- LUI (0110111): addr_a=0, addr_b=0, addr_d=rd, y_sel=0, op=0, immed={instr[31:12],12'b0}.
- Illegal: any other opcode. Outputs are still updated, but write never asserts.
- Outputs hold their last values in IDLE. Only write and illegal self-clear.
- Reset mid-operation, in any state: next cycle state=IDLE and all outputs are at reset values. A write pulse in progress is cancelled on the cycle after rst is sampled.
- instr_valid is ignored outside IDLE. instr_in is not re-sampled until the next handshake.

Optional Feature:
DECODE_STATS_EN
- Defined:
  - retired_count increments in every WB cycle, including rd==0.
  - illegal_count increments on each illegal pulse.
  - Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: both ports tie to 0 and no counter logic is synthesized.

Test Plan:
1. ADD x3,x1,x2 (0x002081B3) -> EXEC shows addr_a=1, addr_b=2, addr_d=3, y_sel=1, op=0x00; write=1 only in WB; instr_ready high again 4 cycles after the handshake.
2. ADDI x5,x0,-1 (0xFFF00293) -> immed=0xFFFFFFFF, y_sel=0, addr_d=5, op=0x00, write pulse 1 cycle.
3. SUB x4,x1,x2 (0x40208233) -> op=0x08.
   SRAI x6,x1,3 (0x4030D313) -> op=0x0D, immed=0x00000003.
4. LUI x7,0x12345 (0x123453B7) -> immed=0x12345000, addr_a=0, op=0x00, addr_d=7, write in WB.
5. 0x00000000 -> illegal=1 for one cycle, write never 1, back in IDLE after 2 cycles.
   ADDI x0,x1,1 (0x00108013) -> write stays 0.
   With DECODE_STATS_EN: illegal_count=1 and retired_count=1 after this pair.
6. rst asserted in the EXEC cycle of case 1 -> write never pulses; all outputs 0 next cycle; a new instruction is accepted on the following cycle.
